// File: rtl/pulse_channel_controller.sv
// pulse_channel_controller: register-programmed sequencer for one NES APU pulse
// channel. Holds the four channel registers, the period timer, the length
// counter and the envelope, and drives the rectangle generator plus the
// channel volume.
//
// Optional build macro: PULSE_SWEEP_EN adds the reg1 sweep unit and sweep mute.
//
// Ports:
//   iClk, duty_cycle_reset   clock, asynchronous active-high reset
//   iApuTick                 APU-cycle strobe that advances the period timer
//   iQuarterFrame            frame-sequencer strobe that clocks the envelope
//   iHalfFrame               frame-sequencer strobe that clocks length/sweep
//   iWrite, iAddr, iData     register write port (reg0..reg3)
//   iChannelEnable           status-register enable; low clears length
//   oGenEnable               one-cycle generator step pulse
//   oDutyType                duty select for the generator
//   oSeqRestart              one-cycle generator phase reset after reg3 write
//   oVolume                  channel volume to the mixer
//   oLengthActive            length counter non-zero
module pulse_channel_controller #(
  parameter int unsigned TIMER_WIDTH = 11,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned VOL_WIDTH   = 4
) (
  input  logic                 iClk,
  input  logic                 duty_cycle_reset,
  input  logic                 iApuTick,
  input  logic                 iQuarterFrame,
  input  logic                 iHalfFrame,
  input  logic                 iWrite,
  input  logic [1:0]           iAddr,
  input  logic [7:0]           iData,
  input  logic                 iChannelEnable,
  output logic                 oGenEnable,
  output logic [1:0]           oDutyType,
  output logic                 oSeqRestart,
  output logic [VOL_WIDTH-1:0] oVolume,
  output logic                 oLengthActive
);

  localparam int unsigned MIN_PERIOD = 8;

  logic                   wr0_c, wr2_c, wr3_c;
  logic [1:0]             duty_q, duty_d;
  logic                   halt_q, halt_d;
  logic                   constvol_q, constvol_d;
  logic [VOL_WIDTH-1:0]   vol_q, vol_d;
  logic [TIMER_WIDTH-1:0] period_q, period_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   start_q, start_d;
  logic [VOL_WIDTH-1:0]   decay_q, decay_d;
  logic [VOL_WIDTH-1:0]   div_q, div_d;
  logic                   gen_en_q, gen_en_d;
  logic                   restart_q, restart_d;
  logic [VOL_WIDTH-1:0]   out_vol_q, out_vol_d;
  logic                   len_active_q, len_active_d;
  logic                   muted_c;

  assign wr0_c = iWrite && (iAddr == 2'd0);
  assign wr2_c = iWrite && (iAddr == 2'd2);
  assign wr3_c = iWrite && (iAddr == 2'd3);

`ifdef PULSE_SWEEP_EN
  logic                   wr1_c;
  logic                   sw_en_q, sw_en_d;
  logic [2:0]             sw_p_q, sw_p_d;
  logic                   sw_neg_q, sw_neg_d;
  logic [2:0]             sw_shift_q, sw_shift_d;
  logic [2:0]             sw_div_q, sw_div_d;
  logic                   sw_reload_q, sw_reload_d;
  logic [TIMER_WIDTH-1:0] sw_delta_c;
  logic [TIMER_WIDTH:0]   sw_sum_c;
  logic [TIMER_WIDTH-1:0] sw_target_c;
  logic                   sw_mute_c;

  assign wr1_c      = iWrite && (iAddr == 2'd1);
  assign sw_delta_c = period_q >> sw_shift_q;
  assign sw_sum_c   = {1'b0, period_q} + {1'b0, sw_delta_c};
  // Negate mode saturates at zero; add mode keeps the low bits for the update.
  assign sw_target_c = sw_neg_q ? ((sw_delta_c > period_q) ? '0 : period_q - sw_delta_c)
                                : sw_sum_c[TIMER_WIDTH-1:0];
  // Only the add-mode target can overflow the 11-bit period.
  assign sw_mute_c  = ~sw_neg_q & sw_sum_c[TIMER_WIDTH];
  assign muted_c    = (len_q == '0) || (period_q < TIMER_WIDTH'(MIN_PERIOD)) || sw_mute_c;
`else
  assign muted_c    = (len_q == '0) || (period_q < TIMER_WIDTH'(MIN_PERIOD));
`endif

  // Next-state logic for registers, timer, length, envelope and outputs.
  always_comb begin
    duty_d       = duty_q;
    halt_d       = halt_q;
    constvol_d   = constvol_q;
    vol_d        = vol_q;
    period_d     = period_q;
    timer_d      = timer_q;
    len_d        = len_q;
    start_d      = start_q;
    decay_d      = decay_q;
    div_d        = div_q;
    gen_en_d     = 1'b0;
    restart_d    = wr3_c;
    out_vol_d    = muted_c ? '0 : (constvol_q ? vol_q : decay_q);
    len_active_d = (len_q != '0);
`ifdef PULSE_SWEEP_EN
    sw_en_d      = sw_en_q;
    sw_p_d       = sw_p_q;
    sw_neg_d     = sw_neg_q;
    sw_shift_d   = sw_shift_q;
    sw_div_d     = sw_div_q;
    sw_reload_d  = sw_reload_q;
`endif

    if (wr0_c) begin
      duty_d     = iData[7:6];
      halt_d     = iData[5];
      constvol_d = iData[4];
      vol_d      = VOL_WIDTH'(iData[3:0]);
    end

    // Period timer: reload on zero and emit one step pulse.
    if (iApuTick) begin
      if (timer_q == '0) begin
        timer_d  = period_q;
        gen_en_d = 1'b1;
      end else begin
        timer_d  = timer_q - TIMER_WIDTH'(1);
      end
    end

`ifdef PULSE_SWEEP_EN
    if (iHalfFrame) begin
      if ((sw_div_q == '0) && sw_en_q && (sw_shift_q != '0) && !muted_c)
        period_d = sw_target_c;
      if ((sw_div_q == '0) || sw_reload_q) begin
        sw_div_d    = sw_p_q;
        sw_reload_d = 1'b0;
      end else begin
        sw_div_d    = sw_div_q - 3'(1);
      end
    end
    if (wr1_c) begin
      sw_en_d     = iData[7];
      sw_p_d      = iData[6:4];
      sw_neg_d    = iData[3];
      sw_shift_d  = iData[2:0];
      sw_reload_d = 1'b1;
    end
`endif

    // Register writes override a same-cycle sweep update of the period.
    if (wr2_c) period_d[7:0] = iData;
    if (wr3_c) period_d[TIMER_WIDTH-1:8] = iData[2:0];

    // Length: a load beats a same-cycle decrement; disable beats everything.
    if (wr3_c)
      len_d = LEN_WIDTH'({iData[7:3], 3'b111});
    else if (iHalfFrame && (len_q != '0) && !halt_q)
      len_d = len_q - LEN_WIDTH'(1);
    if (!iChannelEnable)
      len_d = '0;

    // Envelope runs on the old start flag; a reg3 write re-arms it afterwards.
    if (iQuarterFrame) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = '1;
        div_d   = vol_q;
      end else if (div_q == '0) begin
        div_d = vol_q;
        if (decay_q != '0)
          decay_d = decay_q - VOL_WIDTH'(1);
        else if (halt_q)
          decay_d = '1;
      end else begin
        div_d = div_q - VOL_WIDTH'(1);
      end
    end
    if (wr3_c) start_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge iClk or posedge duty_cycle_reset) begin
    if (duty_cycle_reset) begin
      duty_q       <= '0;
      halt_q       <= 1'b0;
      constvol_q   <= 1'b0;
      vol_q        <= '0;
      period_q     <= '0;
      timer_q      <= '0;
      len_q        <= '0;
      start_q      <= 1'b0;
      decay_q      <= '0;
      div_q        <= '0;
      gen_en_q     <= 1'b0;
      restart_q    <= 1'b0;
      out_vol_q    <= '0;
      len_active_q <= 1'b0;
`ifdef PULSE_SWEEP_EN
      sw_en_q      <= 1'b0;
      sw_p_q       <= '0;
      sw_neg_q     <= 1'b0;
      sw_shift_q   <= '0;
      sw_div_q     <= '0;
      sw_reload_q  <= 1'b0;
`endif
    end else begin
      duty_q       <= duty_d;
      halt_q       <= halt_d;
      constvol_q   <= constvol_d;
      vol_q        <= vol_d;
      period_q     <= period_d;
      timer_q      <= timer_d;
      len_q        <= len_d;
      start_q      <= start_d;
      decay_q      <= decay_d;
      div_q        <= div_d;
      gen_en_q     <= gen_en_d;
      restart_q    <= restart_d;
      out_vol_q    <= out_vol_d;
      len_active_q <= len_active_d;
`ifdef PULSE_SWEEP_EN
      sw_en_q      <= sw_en_d;
      sw_p_q       <= sw_p_d;
      sw_neg_q     <= sw_neg_d;
      sw_shift_q   <= sw_shift_d;
      sw_div_q     <= sw_div_d;
      sw_reload_q  <= sw_reload_d;
`endif
    end
  end

  assign oGenEnable    = gen_en_q;
  assign oDutyType     = duty_q;
  assign oSeqRestart   = restart_q;
  assign oVolume       = out_vol_q;
  assign oLengthActive = len_active_q;

endmodule

// File: tb/tb_pulse_channel_controller.sv
// Testbench for pulse_channel_controller: directed scenarios plus a random
// walk, with a queue-based scoreboard fed by a behavioural channel model.
module tb_pulse_channel_controller;

  logic       iClk = 1'b0;
  logic       duty_cycle_reset = 1'b1;
  logic       iApuTick = 1'b0, iQuarterFrame = 1'b0, iHalfFrame = 1'b0;
  logic       iWrite = 1'b0;
  logic [1:0] iAddr = 2'd0;
  logic [7:0] iData = 8'd0;
  logic       iChannelEnable = 1'b0;
  logic       oGenEnable, oSeqRestart, oLengthActive;
  logic [1:0] oDutyType;
  logic [3:0] oVolume;

  pulse_channel_controller dut (
    .iClk(iClk), .duty_cycle_reset(duty_cycle_reset),
    .iApuTick(iApuTick), .iQuarterFrame(iQuarterFrame), .iHalfFrame(iHalfFrame),
    .iWrite(iWrite), .iAddr(iAddr), .iData(iData), .iChannelEnable(iChannelEnable),
    .oGenEnable(oGenEnable), .oDutyType(oDutyType), .oSeqRestart(oSeqRestart),
    .oVolume(oVolume), .oLengthActive(oLengthActive)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int gen; int duty; int restart; int vol; int lact;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   gen_cnt = 0;

  // Channel model state, plain integers.
  int m_duty, m_halt, m_cv, m_v, m_period, m_timer, m_len, m_start, m_decay, m_div;
  int m_sw_en, m_sw_p, m_sw_neg, m_sw_sh, m_sw_div, m_sw_reload;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_duty = 0; m_halt = 0; m_cv = 0; m_v = 0; m_period = 0; m_timer = 0;
    m_len = 0; m_start = 0; m_decay = 0; m_div = 0;
    m_sw_en = 0; m_sw_p = 0; m_sw_neg = 0; m_sw_sh = 0; m_sw_div = 0; m_sw_reload = 0;
  endtask

  function automatic int sweep_sum();
    return m_period + (m_period >> m_sw_sh);
  endfunction

  function automatic bit model_muted();
    bit mu;
    mu = (m_len == 0) || (m_period < 8);
`ifdef PULSE_SWEEP_EN
    if (m_sw_neg == 0 && sweep_sum() > 2047) mu = 1'b1;
`endif
    return mu;
  endfunction

  // Advance the model by one clock and return what the outputs show afterwards.
  task automatic model_step(input bit tick, input bit qf, input bit hf, input bit wr,
                            input bit [1:0] addr, input bit [7:0] data, input bit en);
    exp_t e;
    bit w0, w1, w2, w3;
    int n_period, n_timer, n_len, n_start, n_decay, n_div, d;
    w0 = wr && addr == 2'd0; w1 = wr && addr == 2'd1;
    w2 = wr && addr == 2'd2; w3 = wr && addr == 2'd3;

    e.gen     = (tick && m_timer == 0) ? 1 : 0;
    e.restart = w3 ? 1 : 0;
    e.vol     = model_muted() ? 0 : (m_cv != 0 ? m_v : m_decay);
    e.lact    = (m_len != 0) ? 1 : 0;

    n_timer = m_timer;
    if (tick) n_timer = (m_timer == 0) ? m_period : m_timer - 1;

    n_period = m_period;
`ifdef PULSE_SWEEP_EN
    if (hf) begin
      if (m_sw_div == 0 && m_sw_en != 0 && m_sw_sh != 0 && !model_muted()) begin
        d = m_period >> m_sw_sh;
        n_period = (m_sw_neg != 0) ? ((m_period - d < 0) ? 0 : m_period - d) : (sweep_sum() % 2048);
      end
      if (m_sw_div == 0 || m_sw_reload != 0) begin m_sw_div = m_sw_p; m_sw_reload = 0; end
      else m_sw_div = m_sw_div - 1;
    end
    if (w1) begin
      m_sw_en = data[7]; m_sw_p = int'(data[6:4]); m_sw_neg = data[3];
      m_sw_sh = int'(data[2:0]); m_sw_reload = 1;
    end
`else
    d = w1 ? 1 : 0;
`endif
    if (w2) n_period = (n_period / 256) * 256 + int'(data);
    if (w3) n_period = (n_period % 256) + int'(data[2:0]) * 256;

    n_len = m_len;
    if (!en) n_len = 0;
    else if (w3) n_len = int'(data[7:3]) * 8 + 7;
    else if (hf && m_len > 0 && m_halt == 0) n_len = m_len - 1;

    n_start = m_start; n_decay = m_decay; n_div = m_div;
    if (qf) begin
      if (m_start != 0) begin n_start = 0; n_decay = 15; n_div = m_v; end
      else if (m_div == 0) begin
        n_div = m_v;
        if (m_decay > 0) n_decay = m_decay - 1;
        else if (m_halt != 0) n_decay = 15;
      end else n_div = m_div - 1;
    end
    if (w3) n_start = 1;

    if (w0) begin
      m_duty = int'(data[7:6]); m_halt = data[5]; m_cv = data[4]; m_v = int'(data[3:0]);
    end
    m_period = n_period; m_timer = n_timer; m_len = n_len;
    m_start = n_start; m_decay = n_decay; m_div = n_div;
    e.duty = m_duty;
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit tick, input bit qf, input bit hf, input bit wr,
                       input bit [1:0] addr, input bit [7:0] data, input bit en);
    @(negedge iClk);
    iApuTick = tick; iQuarterFrame = qf; iHalfFrame = hf;
    iWrite = wr; iAddr = addr; iData = data; iChannelEnable = en;
    model_step(tick, qf, hf, wr, addr, data, en);
  endtask

  task automatic wr_reg(input bit [1:0] addr, input bit [7:0] data);
    drive(1'b0, 1'b0, 1'b0, 1'b1, addr, data, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
  endtask

  // Asynchronous reset between clock edges: outputs must clear at once.
  task automatic do_reset();
    @(negedge iClk);
    duty_cycle_reset = 1'b1;
    iApuTick = 1'b0; iQuarterFrame = 1'b0; iHalfFrame = 1'b0; iWrite = 1'b0;
    #1;
    chk("rst_gen", int'(oGenEnable), 0);
    chk("rst_restart", int'(oSeqRestart), 0);
    chk("rst_duty", int'(oDutyType), 0);
    chk("rst_vol", int'(oVolume), 0);
    chk("rst_lact", int'(oLengthActive), 0);
    model_reset();
    @(negedge iClk);
    duty_cycle_reset = 1'b0;
  endtask

  // Scoreboard monitor: one expected entry per modelled clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge iClk);
      #1;
      if (!duty_cycle_reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("gen", int'(oGenEnable), e.gen);
        chk("duty", int'(oDutyType), e.duty);
        chk("restart", int'(oSeqRestart), e.restart);
        chk("volume", int'(oVolume), e.vol);
        chk("len_active", int'(oLengthActive), e.lact);
      end
    end
  end

  always @(negedge iClk) if (oGenEnable === 1'b1) gen_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Mid-count reset with period 0x010, then quiet with no ticks.
    wr_reg(2'd2, 8'h10);
    wr_reg(2'd3, 8'h08);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    do_reset();
    idle(4);

    // Period 8: one step every 9 ticks; lenidx 0 loads length 7.
    wr_reg(2'd2, 8'h08);
    wr_reg(2'd3, 8'h00);
    gen_cnt = 0;
    for (int i = 0; i < 27; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    idle(2);
    chk("gen_count_27_ticks", gen_cnt, 3);

    // Constant volume 10, then disable the channel.
    do_reset();
    wr_reg(2'd0, 8'h1A);
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd3, 8'h09);
    idle(2);
    chk("constvol_10", int'(oVolume), 10);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    idle(1);
    chk("disabled_lact", int'(oLengthActive), 0);

    // Envelope V=2: 15 for three quarter frames, 14 on the fourth.
    do_reset();
    wr_reg(2'd0, 8'h02);
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd3, 8'h09);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
      idle(1);
    end
    idle(1);
    chk("envelope_4th_qf", int'(oVolume), 14);
    // Loop set: decay walks down and wraps from 0 back to 15.
    wr_reg(2'd0, 8'h22);
    for (int i = 0; i < 52; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    // Reg3 write together with a quarter frame defers the restart.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h09, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);

    // Reg3 write with a half frame: load wins; period 7 mutes.
    do_reset();
    wr_reg(2'd0, 8'h1A);
    wr_reg(2'd2, 8'h07);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 8'h08, 1'b1);
    idle(2);
    chk("period7_muted", int'(oVolume), 0);
    for (int i = 0; i < 14; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
    idle(2);
    chk("len_after_14_hf", int'(oLengthActive), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
    idle(2);
    chk("len_after_15_hf", int'(oLengthActive), 0);

`ifdef PULSE_SWEEP_EN
    // Sweep up by half: 0x400 -> 0x600, whose next target overflows and mutes.
    do_reset();
    wr_reg(2'd0, 8'h1A);
    wr_reg(2'd1, 8'h81);
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd3, 8'h0C);
    idle(2);
    chk("sweep_before", int'(oVolume), 10);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
    idle(2);
    chk("sweep_overflow_mute", int'(oVolume), 0);
`endif

    // Random walk against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 6) == 0),
            2'($urandom_range(0, 3)),
            8'($urandom),
            ($urandom_range(0, 24) != 0));
    end

    @(negedge iClk);
    iApuTick = 1'b0; iQuarterFrame = 1'b0; iHalfFrame = 1'b0; iWrite = 1'b0;
    @(negedge iClk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
